// File: rtl/salu_operand_sequencer.sv
// Sequences one scalar instruction: RF read, operand capture, ALU handshake, result write-back.
// Latency: accept->write-back 5 cycles with no stalls (ERR path 1 cycle); ready again the cycle after.
// Backpressure: holds in ISSUE until alu_ready, in WAIT until res_valid; instr_ready only in IDLE.
module salu_operand_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [7:0]  instr_src0,
    input  logic [7:0]  instr_src1,
    input  logic [7:0]  instr_dst,
    input  logic        instr_is64,
    input  logic        instr_wr,
    output logic [7:0]  rf_s0,
    output logic [7:0]  rf_s1,
    input  logic [63:0] rf_r0,
    input  logic [63:0] rf_r1,
    output logic [7:0]  rf_w0,
    output logic [63:0] rf_wv,
    output logic        rf_en_w,
    output logic        rf_en_64,
    output logic        alu_valid,
    input  logic        alu_ready,
    output logic [63:0] alu_op0,
    output logic [63:0] alu_op1,
    input  logic        res_valid,
    output logic        res_ready,
    input  logic [63:0] res_data,
    output logic        err_ro,
    output logic        err_align,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        CAP   = 3'd2,
        ISSUE = 3'd3,
        WAIT  = 3'd4,
        WB    = 3'd5,
        ERR   = 3'd6
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] dst_q;
    logic       is64_q;
    logic       wr_q;
    logic       accept;
    logic       misalign;
    logic       dst_ro;

    // Read-only SGPR ranges: 0x7D, 0x80-0xE8, 0xF0-0xF8.
    function automatic logic is_ro(input logic [7:0] a);
        return (a == 8'h7D) || (a >= 8'h80 && a <= 8'hE8) || (a >= 8'hF0 && a <= 8'hF8);
    endfunction

    assign instr_ready = (state == IDLE) && !reset;
    assign accept      = instr_valid && instr_ready;
    // Register pairs must start on an even index; dst only matters if it is written.
    assign misalign    = instr_is64 && (instr_src0[0] || instr_src1[0] || (instr_wr && instr_dst[0]));
    // A 64-bit write touches dst and dst+1; either one being read-only blocks the pair.
    assign dst_ro      = is_ro(dst_q) || (is64_q && is_ro(dst_q + 8'd1));

    // State register; reset aborts any in-flight instruction immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-state strobes; strobes only ever assert in their own state.
    always_comb begin
        state_nxt = state;
        alu_valid = 1'b0;
        res_ready = 1'b0;
        rf_en_w   = 1'b0;
        rf_en_64  = 1'b0;
        err_ro    = 1'b0;
        err_align = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = misalign ? ERR : RD;
                end
            end
            RD:    state_nxt = CAP;
            CAP:   state_nxt = ISSUE;
            ISSUE: begin
                alu_valid = 1'b1;
                if (alu_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                res_ready = 1'b1;
                if (res_valid) begin
                    state_nxt = wr_q ? WB : IDLE;
                end
            end
            WB: begin
                rf_en_64  = is64_q;
                rf_en_w   = !dst_ro;
                err_ro    = dst_ro;
                state_nxt = IDLE;
            end
            ERR: begin
                err_align = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: latch fields, drive RF addresses, capture operands and the formatted result.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dst_q   <= 8'h00;
            is64_q  <= 1'b0;
            wr_q    <= 1'b0;
            rf_s0   <= 8'h00;
            rf_s1   <= 8'h00;
            rf_w0   <= 8'h00;
            rf_wv   <= 64'h0;
            alu_op0 <= 64'h0;
            alu_op1 <= 64'h0;
        end else begin
            if (accept) begin
                dst_q  <= instr_dst;
                is64_q <= instr_is64;
                wr_q   <= instr_wr;
                // Dropped instructions leave the read ports untouched.
                if (!misalign) begin
                    rf_s0 <= instr_src0;
                    rf_s1 <= instr_src1;
                end
            end
            // Read data is valid the cycle after the address (CAP); SGPR 0xFF is always 32-bit.
            if (state == CAP) begin
                alu_op0 <= (is64_q && rf_s0 != 8'hFF) ? rf_r0 : {32'h0, rf_r0[31:0]};
                alu_op1 <= (is64_q && rf_s1 != 8'hFF) ? rf_r1 : {32'h0, rf_r1[31:0]};
            end
            if (state == WAIT && res_valid) begin
                rf_wv <= is64_q ? res_data : {32'h0, res_data[31:0]};
                if (wr_q) begin
                    rf_w0 <= dst_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_salu_operand_sequencer.sv
// Bench for salu_operand_sequencer: RF read model, per-instruction driver, write-back scoreboard.
// Latency: checks cycle-exact state progression for every instruction driven.
// Backpressure: exercises alu_ready and res_valid stalls plus early results.
module tb_salu_operand_sequencer;

    logic        clock;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  instr_src0;
    logic [7:0]  instr_src1;
    logic [7:0]  instr_dst;
    logic        instr_is64;
    logic        instr_wr;
    logic [7:0]  rf_s0;
    logic [7:0]  rf_s1;
    logic [63:0] rf_r0;
    logic [63:0] rf_r1;
    logic [7:0]  rf_w0;
    logic [63:0] rf_wv;
    logic        rf_en_w;
    logic        rf_en_64;
    logic        alu_valid;
    logic        alu_ready;
    logic [63:0] alu_op0;
    logic [63:0] alu_op1;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] res_data;
    logic        err_ro;
    logic        err_align;
    logic        busy;

    typedef struct {
        logic [1:0]  kind;   // 0 write, 1 read-only suppressed, 2 misaligned
        logic [7:0]  addr;
        logic [63:0] data;
        logic        en64;
    } exp_t;

    exp_t        sb_q[$];
    logic [63:0] mem [256];
    logic [7:0]  last_s0;
    logic [7:0]  last_s1;
    int          n_checks = 0;
    int          n_errors = 0;

    salu_operand_sequencer dut (
        .clock(clock), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_src0(instr_src0), .instr_src1(instr_src1), .instr_dst(instr_dst),
        .instr_is64(instr_is64), .instr_wr(instr_wr),
        .rf_s0(rf_s0), .rf_s1(rf_s1), .rf_r0(rf_r0), .rf_r1(rf_r1),
        .rf_w0(rf_w0), .rf_wv(rf_wv), .rf_en_w(rf_en_w), .rf_en_64(rf_en_64),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_op0(alu_op0), .alu_op1(alu_op1),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .err_ro(err_ro), .err_align(err_align), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Register file model: registered read, data one cycle after the address.
    always @(posedge clock) begin
        rf_r0 <= mem[rf_s0];
        rf_r1 <= mem[rf_s1];
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic ro_reg(input logic [7:0] a);
        return a inside {8'h7D, [8'h80:8'hE8], [8'hF0:8'hF8]};
    endfunction

    // Scoreboard: every write-back, read-only suppression or alignment error pops one expectation.
    always @(negedge clock) begin
        exp_t       e;
        logic [1:0] kind_obs;
        if (rf_en_w || err_ro || err_align) begin
            kind_obs = err_align ? 2'd2 : (err_ro ? 2'd1 : 2'd0);
            if (sb_q.size() == 0) begin
                check_val("sb_unexpected_event", {62'h0, kind_obs}, 64'h3);
            end else begin
                e = sb_q.pop_front();
                check_val("sb_kind", {62'h0, kind_obs}, {62'h0, e.kind});
                if (e.kind != 2'd2) begin
                    check_val("sb_addr", {56'h0, rf_w0}, {56'h0, e.addr});
                    check_val("sb_data", rf_wv, e.data);
                    check_val("sb_en64", {63'h0, rf_en_64}, {63'h0, e.en64});
                end
                if (e.kind == 2'd1) check_val("sb_ro_no_en", {63'h0, rf_en_w}, 64'h0);
                if (e.kind == 2'd2) check_val("sb_align_no_alu", {63'h0, alu_valid}, 64'h0);
            end
        end
    end

    // Drives one instruction from IDLE to completion and checks the cycle-by-cycle progression.
    task automatic run_instr(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                             input logic [7:0] d, input logic is64, input logic wr,
                             input int alu_stall, input int res_stall, input logic early,
                             input logic [63:0] res);
        exp_t        e;
        logic        align;
        logic        ro;
        logic [63:0] op0;
        logic [63:0] op1;
        int          guard;
        align = is64 && (s0[0] || s1[0] || (wr && d[0]));
        ro    = ro_reg(d) || (is64 && ro_reg(d + 8'd1));
        op0   = (is64 && s0 != 8'hFF) ? mem[s0] : {32'h0, mem[s0][31:0]};
        op1   = (is64 && s1 != 8'hFF) ? mem[s1] : {32'h0, mem[s1][31:0]};
        guard = 0;
        while (!instr_ready && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        check_val({tag, "_idle_ready"}, {63'h0, instr_ready}, 64'h1);
        e.kind = align ? 2'd2 : (ro ? 2'd1 : 2'd0);
        e.addr = d;
        e.data = is64 ? res : {32'h0, res[31:0]};
        e.en64 = is64;
        if (align || wr) sb_q.push_back(e);
        instr_src0 = s0; instr_src1 = s1; instr_dst = d;
        instr_is64 = is64; instr_wr = wr; instr_valid = 1'b1;
        @(negedge clock);                                    // cycle 1
        instr_valid = 1'b0;
        if (align) begin
            check_val({tag, "_err_align_c1"}, {63'h0, err_align}, 64'h1);
            check_val({tag, "_align_rf_s0_held"}, {56'h0, rf_s0}, {56'h0, last_s0});
            @(negedge clock);                                // cycle 2
            check_val({tag, "_ready_c2"}, {63'h0, instr_ready}, 64'h1);
            return;
        end
        last_s0 = s0;
        last_s1 = s1;
        check_val({tag, "_rd_s0"}, {56'h0, rf_s0}, {56'h0, s0});
        check_val({tag, "_rd_s1"}, {56'h0, rf_s1}, {56'h0, s1});
        check_val({tag, "_rd_busy"}, {63'h0, busy}, 64'h1);
        @(negedge clock);                                    // cycle 2, CAP
        check_val({tag, "_cap_no_valid"}, {63'h0, alu_valid}, 64'h0);
        @(negedge clock);                                    // cycle 3, ISSUE
        for (int i = 0; i <= alu_stall; i++) begin
            check_val({tag, "_issue_valid"}, {63'h0, alu_valid}, 64'h1);
            check_val({tag, "_issue_op0"}, alu_op0, op0);
            check_val({tag, "_issue_op1"}, alu_op1, op1);
            check_val({tag, "_issue_res_rdy"}, {63'h0, res_ready}, 64'h0);
            if (i < alu_stall) begin
                alu_ready = 1'b0;
                res_valid = early;
                res_data  = 64'hDEAD_BEEF_DEAD_BEEF;
            end else begin
                alu_ready = 1'b1;
                res_valid = 1'b0;
            end
            @(negedge clock);
        end
        alu_ready = 1'b0;
        for (int j = 0; j <= res_stall; j++) begin
            check_val({tag, "_wait_res_rdy"}, {63'h0, res_ready}, 64'h1);
            check_val({tag, "_wait_no_valid"}, {63'h0, alu_valid}, 64'h0);
            if (j < res_stall) begin
                res_valid = 1'b0;
            end else begin
                res_valid = 1'b1;
                res_data  = res;
            end
            @(negedge clock);
        end
        res_valid = 1'b0;
        res_data  = ~res;
        if (wr) begin
            check_val({tag, "_wb_cycle"}, {63'h0, rf_en_w | err_ro}, 64'h1);
            @(negedge clock);
        end else begin
            check_val({tag, "_nowr_no_en"}, {63'h0, rf_en_w}, 64'h0);
        end
        check_val({tag, "_ready_after"}, {63'h0, instr_ready}, 64'h1);
        check_val({tag, "_idle_busy"}, {63'h0, busy}, 64'h0);
    endtask

    initial begin
        for (int k = 0; k < 256; k++) begin
            mem[k] = {k[7:0], 24'h5A5A5A, ~k[7:0], 24'hC3C3C3};
        end
        mem[8'h04] = 64'hAAAA_0000_1111_2222;
        mem[8'h05] = 64'h0000_0000_0000_0003;
        last_s0 = 8'h00;
        last_s1 = 8'h00;
        reset = 1'b1;
        instr_valid = 1'b0; instr_src0 = 8'h0; instr_src1 = 8'h0; instr_dst = 8'h0;
        instr_is64 = 1'b0; instr_wr = 1'b0;
        alu_ready = 1'b0; res_valid = 1'b0; res_data = 64'h0;

        // Reset state
        @(negedge clock);
        check_val("rst_ready_low", {63'h0, instr_ready}, 64'h0);
        check_val("rst_busy", {63'h0, busy}, 64'h0);
        reset = 1'b0;
        @(negedge clock);
        check_val("rst_ready_high", {63'h0, instr_ready}, 64'h1);
        check_val("rst_op0", alu_op0, 64'h0);
        check_val("rst_wv", rf_wv, 64'h0);
        check_val("rst_s0", {56'h0, rf_s0}, 64'h0);

        run_instr("t32",     8'h04, 8'h05, 8'h06, 1'b0, 1'b1, 0, 0, 1'b0, 64'hFFFF_FFFF_1234_5678);
        run_instr("t64stl",  8'h10, 8'h14, 8'h12, 1'b1, 1'b1, 3, 2, 1'b1, 64'h0123_4567_89AB_CDEF);
        run_instr("ro7d",    8'h02, 8'h03, 8'h7D, 1'b0, 1'b1, 0, 0, 1'b0, 64'h1111_2222_3333_4444);
        run_instr("ro7c64",  8'h02, 8'h04, 8'h7C, 1'b1, 1'b1, 0, 1, 1'b0, 64'h5555_6666_7777_8888);
        run_instr("roE8",    8'h20, 8'h21, 8'hE8, 1'b0, 1'b1, 1, 0, 1'b0, 64'h0000_0000_9999_AAAA);
        run_instr("okE9",    8'h20, 8'h21, 8'hE9, 1'b0, 1'b1, 0, 0, 1'b0, 64'hBBBB_CCCC_DDDD_EEEE);
        run_instr("ok7e64",  8'h30, 8'h32, 8'h7E, 1'b1, 1'b1, 0, 0, 1'b0, 64'hFEDC_BA98_7654_3210);
        run_instr("roF8",    8'h22, 8'h23, 8'hF8, 1'b0, 1'b1, 0, 0, 1'b0, 64'h0000_0001_0000_0002);
        run_instr("mis_s1",  8'h06, 8'h07, 8'h08, 1'b1, 1'b1, 0, 0, 1'b0, 64'h0);
        run_instr("mis_dst", 8'h06, 8'h08, 8'h09, 1'b1, 1'b1, 0, 0, 1'b0, 64'h0);
        run_instr("nowr64",  8'h06, 8'h08, 8'h09, 1'b1, 1'b0, 0, 0, 1'b0, 64'h1234);
        run_instr("nowr",    8'h08, 8'h09, 8'h0A, 1'b0, 1'b0, 2, 1, 1'b1, 64'h9876);
        run_instr("src_ff",  8'hFF, 8'h40, 8'h41, 1'b0, 1'b1, 0, 0, 1'b0, 64'hAAAA_BBBB_CCCC_DDDD);

        for (int k = 0; k < 10; k++) begin
            run_instr("rnd", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                      8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                      {$urandom, $urandom});
        end

        // Reset while waiting for the result: no write-back may follow.
        @(negedge clock);
        instr_src0 = 8'h04; instr_src1 = 8'h05; instr_dst = 8'h06;
        instr_is64 = 1'b0; instr_wr = 1'b1; instr_valid = 1'b1;
        @(negedge clock);
        instr_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        alu_ready = 1'b1;
        @(negedge clock);
        alu_ready = 1'b0;
        check_val("rstmid_in_wait", {63'h0, res_ready}, 64'h1);
        reset = 1'b1;
        #1;
        check_val("rstmid_busy", {63'h0, busy}, 64'h0);
        check_val("rstmid_ready_low", {63'h0, instr_ready}, 64'h0);
        check_val("rstmid_res_rdy", {63'h0, res_ready}, 64'h0);
        check_val("rstmid_op0", alu_op0, 64'h0);
        check_val("rstmid_s0", {56'h0, rf_s0}, 64'h0);
        check_val("rstmid_wv", rf_wv, 64'h0);
        res_valid = 1'b1;
        res_data  = 64'h0BAD_0BAD_0BAD_0BAD;
        @(negedge clock);
        reset = 1'b0;
        last_s0 = 8'h00;
        last_s1 = 8'h00;
        @(negedge clock);
        check_val("rstmid_ready_high", {63'h0, instr_ready}, 64'h1);
        check_val("rstmid_no_wb", {63'h0, rf_en_w}, 64'h0);
        check_val("rstmid_wv_clear", rf_wv, 64'h0);
        res_valid = 1'b0;
        repeat (3) @(negedge clock);

        check_val("sb_empty", 64'(sb_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/salu_operand_sequencer.md
# salu_operand_sequencer

- Initiator-side controller for the scalar register file. It sits between the scalar instruction decoder and the scalar ALU.
- Per instruction, it:
  - issues source addresses to the register file;
  - waits out the register file's one-cycle registered read;
  - hands the operands to the ALU over a valid/ready handshake;
  - accepts the result and issues the write-back (32- or 64-bit).
- Write-backs to read-only SGPR ranges and misaligned 64-bit accesses are suppressed and flagged here, so the register file never receives them.

## Interface
- No parameters. Address width is 8, word width 32, operand width 64.
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `instr_valid` in 1: decoded instruction present.
- `instr_ready` out 1: sequencer can accept an instruction (`state==IDLE && !reset`).
- `instr_src0`, `instr_src1` in 8 each: source SGPR indices.
- `instr_dst` in 8: destination SGPR index.
- `instr_is64` in 1: operands and result are 64-bit register pairs.
- `instr_wr` in 1: instruction writes `instr_dst`.
- `rf_s0`, `rf_s1` out 8 each: register-file read addresses.
- `rf_r0`, `rf_r1` in 64 each: register-file read data, registered (valid one cycle after address).
- `rf_w0` out 8: write address.
- `rf_wv` out 64: write data.
- `rf_en_w` out 1: write enable (one-cycle pulse).
- `rf_en_64` out 1: 64-bit write.
- `alu_valid` out 1, `alu_ready` in 1: operand handshake.
- `alu_op0`, `alu_op1` out 64 each: captured operands.
- `res_valid` in 1, `res_ready` out 1: result handshake.
- `res_data` in 64: ALU result.
- `err_ro` out 1: one-cycle pulse, write to a read-only destination was suppressed.
- `err_align` out 1: one-cycle pulse, misaligned 64-bit access; instruction dropped.
- `busy` out 1: high when `state != IDLE`.

## Operation
- States:
  - **IDLE:** instruction accepted on `instr_valid && instr_ready`; fields latched.
    - If `instr_is64` and any of src0/src1 is odd, or (`instr_wr` and dst is odd) -> **ERR**.
    - Otherwise -> **RD**.
  - **RD:** `rf_s0`/`rf_s1` driven from the latched sources -> **CAP**.
  - **CAP:** addresses held; `rf_r0`/`rf_r1` captured into `alu_op0`/`alu_op1` at the end of the cycle.
    - If `!instr_is64`, bits [63:32] of both operands are forced to 0.
    - Source 0xFF is always treated as 32-bit (upper bits zeroed).
    - -> **ISSUE**.
  - **ISSUE:** `alu_valid=1`, operands held stable until `alu_ready` -> **WAIT**.
  - **WAIT:** `res_ready=1`. On `res_valid`, `res_data` is latched.
    - -> **WB** if `instr_wr`, else -> **IDLE**.
  - **WB:** `rf_w0=dst`, `rf_en_64=instr_is64`.
    - `rf_wv = res` if 64-bit, else `{32'b0, res[31:0]}`.
    - If dst is read-only: `rf_en_w=0` and `err_ro=1`; otherwise `rf_en_w=1`.
    - -> **IDLE**.
  - **ERR:** `err_align=1` for one cycle, no register-file or ALU activity -> **IDLE**.
- Read-only set: 0x7D, 0x80–0xE8, 0xF0–0xF8. For 64-bit writes, the pair is read-only if dst or dst+1 is in the set.
- `rf_en_w`, `alu_valid`, `res_ready`, `err_*` are asserted only in their named states.
- `rf_s*` and `rf_w0` hold their last value elsewhere.

## Timing
- **Reset values:**
  - state IDLE; `instr_ready` 0 while reset is asserted, 1 in the first cycle after release;
  - all other outputs 0, operand and result registers 0.
- **Reset mid-operation:** immediate abort to IDLE; no write-back and no error pulse is ever issued for the aborted instruction.
- **Zero-stall latency:** accept at edge E0; then:
  - RD cycle 1, CAP cycle 2, ISSUE cycle 3, WAIT cycle 4, WB cycle 5;
  - `instr_ready` high again in cycle 6.
- **Throughput:** one instruction per 6 cycles (5 if `!instr_wr`, 2 for ERR).
- **Stalls:** each cycle of `alu_ready=0` or `res_valid=0` adds one cycle; the held outputs are unchanged during the stall.
- **Early result:** `res_valid` asserted during ISSUE is ignored (`res_ready=0`).
- **Hazard:** a read of a register written in the previous instruction's WB is safe, because RD follows WB by at least 2 cycles.

## Test plan
- **32-bit instruction, zero stalls.**
  - Stimulus: src0=0x04, src1=0x05, dst=0x06; RF returns 0xAAAA_0000_1111_2222 and 0x0000_0000_0000_0003; ALU returns 0xFFFF_FFFF_1234_5678.
  - Required: `alu_op0` = 0x0000_0000_1111_2222; in cycle 5, `rf_w0`=0x06, `rf_wv`=0x0000_0000_1234_5678, `rf_en_w`=1, `rf_en_64`=0; `instr_ready` high again in cycle 6.
- **64-bit instruction with ALU stalls.**
  - Stimulus: src0=0x10, dst=0x12, `instr_is64`=1; `alu_ready` held low 3 cycles; `res_valid` delayed 2 cycles.
  - Required: operands stable throughout the stalls; write-back of the full 64-bit result with `rf_en_64`=1 in cycle 10.
- **Read-only destinations.**
  - Stimulus: dst=0x7D (32-bit), and dst=0x7C with `instr_is64`=1 (covers 0x7D).
  - Required: `err_ro` pulses and `rf_en_w` stays 0 in both cases.
- **Misaligned 64-bit access.**
  - Stimulus: 64-bit instruction with src1=0x07.
  - Required: `err_align` pulses in cycle 1; no `alu_valid`; `instr_ready` high in cycle 2.
- **No-write instruction.**
  - Stimulus: `instr_wr`=0.
  - Required: no WB state; `instr_ready` high in cycle 5.
- **Reset mid-operation.**
  - Stimulus: assert `reset` in the WAIT state, then supply `res_valid`.
  - Required: `rf_en_w` never asserted; all outputs 0; `instr_ready`=1 one cycle after reset release.
